// File: rtl/ifu_pc.sv
// Fetch-unit program counter: next-PC selection, legal-range guard and a
// two-state run/halt controller with an accepted-update counter.
module ifu_pc #(
    parameter logic [31:0] PC_INIT = 32'h0000_3000,
    parameter logic [31:0] PC_MAX  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  npcOp,
    input  logic        cmpRes,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rsData,
    output logic [31:0] pc,
    output logic [31:0] pcLink,
    output logic [31:0] npc,
    output logic        err,
    output logic [31:0] cnt
);

    // state   | meaning
    // ST_RUN  | fetching; enabled edges load npc when it is a legal target
    // ST_HALT | illegal target seen; everything frozen until reset
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [2:0] OP_SEQ    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;

    logic [0:0]  state;
    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic        legal;

    assign seq_pc = pc + 32'd4;
    assign pcLink = seq_pc;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = seq_pc;
        case (npcOp)
            OP_SEQ:    npc = seq_pc;
            OP_BRANCH: npc = cmpRes ? (seq_pc + br_off) : seq_pc;
            OP_JUMP:   npc = {pc[31:28], imm26, 2'b00};
            OP_JR:     npc = rsData;
            default:   npc = seq_pc;
        endcase
    end

    assign legal = (npc[1:0] == 2'b00) && (npc >= PC_INIT) && (npc <= PC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= PC_INIT;
            cnt   <= 32'd0;
            err   <= 1'b0;
            state <= ST_RUN;
        end else if (state == ST_RUN && en) begin
            if (legal) begin
                pc  <= npc;
                cnt <= cnt + 32'd1;
            end else begin
                // pc and cnt keep the last good values for post-mortem
                err   <= 1'b1;
                state <= ST_HALT;
            end
        end
    end

endmodule
